ram_burst_ctrl: RTL and testbench

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

---
 rtl/ram_burst_ctrl.sv | 143 ++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst controller that turns write/read commands into single-port RAM accesses.
// Optional macro RAM_BURST_WRAP_EN: bursts wrap modulo 2^AW instead of being range-checked.
module ram_burst_ctrl #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] wdata,
  input  logic          wvalid,
  output logic          wready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  input  logic          rready,
  output logic          done,
  output logic          err,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic [AW-1:0] left;
  logic [DW-1:0] fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_cnt;
  logic          inflight;
  logic          done_q, err_q;
  logic          accept, bad_range, wbeat, issue, pop;
  logic [2:0]    occupancy;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rvalid    = (fifo_cnt != 2'd0);
  assign rdata     = fifo_mem[rd_ptr];
  assign pop       = rvalid && rready;
  assign done      = done_q;
  assign err       = err_q;

  // Words already committed to the output side after this cycle's pop.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};

`ifdef RAM_BURST_WRAP_EN
  assign bad_range = 1'b0;
`else
  assign bad_range = ({1'b0, cmd_addr} + {1'b0, cmd_len}) > {1'b0, {AW{1'b1}}};
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal gets a default first, so no path through the case leaves a latch.
  always_comb begin
    state_nxt = state;
    wready    = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_di    = '0;
    wbeat     = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !bad_range) state_nxt = cmd_wr ? WRITE : READ;
      end
      WRITE: begin
        wready   = 1'b1;
        ram_en   = wvalid;
        ram_we   = wvalid;
        ram_addr = addr;
        ram_di   = wdata;
        wbeat    = wvalid;
        if (wvalid && left == '0) state_nxt = IDLE;
      end
      READ: begin
        ram_addr = addr;
        if (occupancy < 3'd2) begin
          ram_en = 1'b1;
          issue  = 1'b1;
          if (left == '0) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight && fifo_cnt == {1'b0, pop}) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      left     <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      inflight <= issue;
      err_q    <= accept && bad_range;
      done_q   <= (state != IDLE) && (state_nxt == IDLE);
      if (accept) begin
        addr <= cmd_addr;
        left <= cmd_len;
      end else if (wbeat || issue) begin
        addr <= addr + AW'(1);
        left <= left - AW'(1);
      end
    end
  end

  // Read data lands one cycle after its issue; the issue throttle keeps this from overflowing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two FIFO words are reset (unlike a RAM) because rdata must read 0 in reset.
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_mem[wr_ptr] <= ram_dout;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl: a RAM model, a reference memory array and a
// negedge monitor that checks every RAM access and every read beat against queued expectations.
module tb_ram_burst_ctrl;
  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic [DW-1:0] wdata;
  logic          wvalid, wready;
  logic [DW-1:0] rdata;
  logic          rvalid, rready;
  logic          done, err;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di, ram_dout;

  ram_burst_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .done(done), .err(err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_di(ram_di), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  wr_t           wr_q[$];
  logic [DW-1:0] rd_q[$];
  logic [AW-1:0] rd_addr_q[$];

  int errors = 0;
  int checks = 0;
  int issued = 0;
  int popped = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous single-port RAM: read data appears one cycle after the enable edge.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_di;
      else        ram_dout <= ram_mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      logic pop_now;
      pop_now = rvalid && rready;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (prev_stall) begin
        check("rvalid_hold", rvalid, 1);
        check("rdata_stable", rdata, prev_rdata);
      end
      prev_stall = rvalid && !rready;
      prev_rdata = rdata;
      if (ram_en && ram_we) begin
        if (wr_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check("write_addr", ram_addr, w.addr);
          check("write_data", ram_di, w.data);
        end
      end
      if (ram_en && !ram_we) begin
        check("read_occupancy", (issued - popped - int'(pop_now)) < 2, 1);
        issued++;
        if (rd_addr_q.size() == 0) check("unexpected_read", 1, 0);
        else check("read_addr", ram_addr, rd_addr_q.pop_front());
      end
      if (pop_now) begin
        popped++;
        if (rd_q.size() == 0) check("unexpected_rvalid", 1, 0);
        else check("read_data", rdata, rd_q.pop_front());
      end
    end
  end

  task automatic send_cmd(input logic wr, input int addr, input int len);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = AW'(len);
    @(negedge clk);
    check("cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
    cmd_len   = AW'($urandom);
  endtask

  task automatic do_write(input int addr, input int len, input bit stall, input bit seq);
    send_cmd(1'b1, addr, len);
    for (int i = 0; i <= len; i++) begin
      wr_t w;
      if (stall) begin
        while ($urandom_range(0, 2) == 0) begin
          wvalid = 1'b0;
          @(negedge clk);
          check("stall_no_ram_en", ram_en, 0);
          @(posedge clk); #1;
        end
      end
      wvalid = 1'b1;
      wdata  = seq ? DW'(16'hA000 + i) : DW'($urandom);
      w.addr = AW'(addr + i);
      w.data = wdata;
      wr_q.push_back(w);
      ref_mem[(addr + i) % DEPTH] = wdata;
      @(negedge clk);
      check("wready", wready, 1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    @(negedge clk);
    check("write_done", done, 1);
    check("write_q_empty", wr_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // mode 0: rready held high, 1: toggles every cycle, 2: random.
  task automatic do_read(input int addr, input int len, input int mode, input bit timed);
    int cyc = 0;
    int first_rv = -1;
    int done_cyc = -1;
    for (int i = 0; i <= len; i++) begin
      rd_q.push_back(ref_mem[(addr + i) % DEPTH]);
      rd_addr_q.push_back(AW'(addr + i));
    end
    send_cmd(1'b0, addr, len);
    while (done_cyc < 0 && cyc < 8 * len + 64) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (cyc % 2 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (rvalid && first_rv < 0) first_rv = cyc;
      if (done) done_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    check("read_done", done_cyc >= 0, 1);
    if (timed) begin
      check("first_rvalid_cycle", first_rv, 2);
      check("read_done_cycle", done_cyc, 2 + len + 1);
    end
    check("read_q_empty", rd_q.size(), 0);
    check("read_addr_q_empty", rd_addr_q.size(), 0);
    rd_q.delete();
    rd_addr_q.delete();
    @(negedge clk);
    check("done_pulse_width", done, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_ram_en"}, ram_en, 0);
    check({tag, "_ram_we"}, ram_we, 0);
    check({tag, "_wready"}, wready, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_di"}, ram_di, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_err = 0;
    int done_before;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] <= DW'(i * 3 + 1);
      ref_mem[i] = DW'(i * 3 + 1);
    end
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata = '0; wvalid = 1'b0; rready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed write then read of 0xA000..0xA003 at 0x010.
    do_write(32'h010, 3, 1'b0, 1'b1);
    do_read(32'h010, 3, 0, 1'b1);

    // Single-word burst and an 8-word burst with rready toggling.
    do_write(32'h020, 0, 1'b0, 1'b0);
    do_read(32'h020, 0, 0, 1'b1);
    do_write(32'h200, 7, 1'b0, 1'b0);
    do_read(32'h200, 7, 1, 1'b0);

    // Burst ending exactly on the top address is legal in either build.
    do_write(32'h3FC, 3, 1'b1, 1'b0);
    do_read(32'h3FC, 3, 2, 1'b0);

`ifdef RAM_BURST_WRAP_EN
    do_write(32'h3FE, 3, 1'b0, 1'b0);
    do_read(32'h3FE, 3, 0, 1'b1);
`else
    send_cmd(1'b1, 32'h3FE, 3);
    @(negedge clk);
    check("err_pulse_wr", err, 1);
    check("err_cmd_ready", cmd_ready, 1);
    check("err_no_wready", wready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("err_single_cycle", err, 0);
    check("err_no_done", done, 0);
    @(posedge clk); #1;
    send_cmd(1'b0, 32'h3FF, 1);
    @(negedge clk);
    check("err_pulse_rd", err, 1);
    check("err_rd_no_ram_en", ram_en, 0);
    @(posedge clk); #1;
    exp_err = 2;
`endif

    // Random in-range bursts with write stalls and random read backpressure.
    for (int n = 0; n < 12; n++) begin
      int len;
      int addr;
      len  = $urandom_range(0, 20);
      addr = $urandom_range(0, DEPTH - 1 - len);
      do_write(addr, len, 1'b1, 1'b0);
      do_read(addr, len, 2, 1'b0);
    end
    do_write(32'h000, 63, 1'b0, 1'b0);
    do_read(32'h000, 63, 0, 1'b1);

    // Reset during the second beat of a 4-beat write.
    done_before = done_cnt;
    send_cmd(1'b1, 32'h100, 3);
    begin
      wr_t w;
      wvalid = 1'b1;
      wdata  = 16'hBEEF;
      w.addr = AW'(32'h100);
      w.data = wdata;
      wr_q.push_back(w);
      ref_mem[32'h100] = wdata;
      @(posedge clk); #1;
      wdata  = 16'h1234;
      w.data = wdata;
      w.addr = AW'(32'h101);
      wr_q.push_back(w);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midburst");
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt, done_before);
    check("reset_write_q_empty", wr_q.size(), 0);
    do_read(32'h100, 1, 0, 1'b1);

    check("err_count", err_cnt, exp_err);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
